// File: rtl/dff_reg_arbiter_if.sv
// Purpose : bundles the requester handshake and the shared-register write
//           path used by dff_reg_arbiter.
// Signals : req/wdata   requester requests and per-requester write data
//           gnt/done/err grant, completion and failure pulses to requesters
//           reg_we/reg_d write enable and data to the shared d_ff register
//           reg_q        readback from the shared register
//           busy         arbiter is inside a transaction
// Modports: master = arbiter side, slave = requester/register side.
interface dff_reg_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [WIDTH-1:0]       reg_q;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   err;
    logic                   reg_we;
    logic [WIDTH-1:0]       reg_d;
    logic                   busy;

    modport master (
        input  req, wdata, reg_q,
        output gnt, done, err, reg_we, reg_d, busy
    );

    modport slave (
        output req, wdata, reg_q,
        input  gnt, done, err, reg_we, reg_d, busy
    );
endinterface

// File: rtl/dff_reg_arbiter.sv
// Purpose : round-robin write arbiter for one shared WIDTH-bit d_ff register.
//           Grants one requester, writes its data for one cycle, reads the
//           register back and retries up to MAX_RETRY times on mismatch.
// Ports   : clk  rising-edge clock
//           rst  asynchronous active-high reset
//           bus  dff_reg_arbiter_if.master (req/wdata/reg_q in;
//                gnt/done/err/reg_we/reg_d/busy out, all registered)
module dff_reg_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    dff_reg_arbiter_if.master     bus
);

    localparam int unsigned PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned RETRY_W = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               err_q, err_d;
    logic               we_q, we_d;
    logic [WIDTH-1:0]   reg_d_q, reg_d_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic [N_REQ-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [RETRY_W-1:0] retry_q, retry_d;

    logic [WIDTH-1:0]   wdata_arr [N_REQ];
    logic               win_found_c;
    logic [PTR_W-1:0]   win_idx_c;
    logic               mismatch_c;
    logic               can_retry_c;

    // Split the flat write-data bus into per-requester words.
    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_wdata
        assign wdata_arr[g] = bus.wdata[g*WIDTH +: WIDTH];
    end

    // Winner: first requesting index at or above the pointer, wrapping.
    always_comb begin
        int unsigned cand;
        win_found_c = 1'b0;
        win_idx_c   = '0;
        cand        = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!win_found_c && bus.req[PTR_W'(cand)]) begin
                win_found_c = 1'b1;
                win_idx_c   = PTR_W'(cand);
            end
        end
    end

    assign mismatch_c  = (bus.reg_q != hold_q);
    assign can_retry_c = (retry_q < RETRY_W'(MAX_RETRY));

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            reg_d_q <= '0;
            busy_q  <= 1'b0;
            hold_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            we_q    <= we_d;
            reg_d_q <= reg_d_d;
            busy_q  <= busy_d;
            hold_q  <= hold_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            retry_q <= retry_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = VERIFY;
            end
            VERIFY: begin
                if (mismatch_c && can_retry_c) begin
                    state_d = WRITE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        gnt_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        we_d    = 1'b0;
        reg_d_d = reg_d_q;
        hold_d  = hold_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        retry_d = retry_q;
        case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    hold_d  = wdata_arr[win_idx_c];
                    reg_d_d = wdata_arr[win_idx_c];
                    we_d    = 1'b1;
                    gnt_d   = N_REQ'(1) << win_idx_c;
                    owner_d = N_REQ'(1) << win_idx_c;
                    retry_d = '0;
                    if (win_idx_c == PTR_W'(N_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx_c + PTR_W'(1);
                    end
                end
            end
            VERIFY: begin
                if (!mismatch_c) begin
                    done_d = owner_q;
                end else if (can_retry_c) begin
                    // Rewrite the held data; the grant is not repeated.
                    retry_d = retry_q + RETRY_W'(1);
                    we_d    = 1'b1;
                end else begin
                    done_d = owner_q;
                    err_d  = 1'b1;
                end
            end
            default: begin
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.gnt    = gnt_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.reg_we = we_q;
    assign bus.reg_d  = reg_d_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Directed bench for dff_reg_arbiter with a behavioural shared register
// that can be stuck or made to corrupt a number of writes.
module tb_dff_reg_arbiter;

    localparam int unsigned N_REQ     = 4;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned MAX_RETRY = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dff_reg_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

    dff_reg_arbiter #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Shared register model: captures reg_d on reg_we, optionally corrupting.
    logic [WIDTH-1:0] model_q;
    int unsigned      wr_count;
    int unsigned      corrupt_until = 0;
    logic             stuck_en = 1'b0;
    logic [WIDTH-1:0] stuck_val = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q  <= '0;
            wr_count <= 0;
        end else if (bus.reg_we) begin
            wr_count <= wr_count + 1;
            model_q  <= (wr_count < corrupt_until) ? ~bus.reg_d : bus.reg_d;
        end
    end

    assign bus.reg_q = stuck_en ? stuck_val : model_q;

    task automatic do_reset;
        rst           = 1'b1;
        bus.req       = '0;
        bus.wdata     = '0;
        stuck_en      = 1'b0;
        corrupt_until = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        bus.req   = 4'b1111;
        bus.wdata = 32'h4433_2211;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt); end
        checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL reset_done got %b exp 0000", bus.done); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
        checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", bus.reg_we); end
        checks++; if (bus.reg_d !== 8'h00) begin errors++; $display("FAIL reset_regd got %h exp 00", bus.reg_d); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_single;
        logic [3:0] eg, ed;
        do_reset();
        bus.wdata = 32'h0000_00A5;
        bus.req   = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            eg = (c == 1) ? 4'b0001 : 4'b0000;
            ed = (c == 3) ? 4'b0001 : 4'b0000;
            checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL single_gnt c%0d got %b exp %b", c, bus.gnt, eg); end
            checks++; if (bus.reg_we !== (c == 1)) begin errors++; $display("FAIL single_we c%0d got %b exp %b", c, bus.reg_we, (c == 1)); end
            checks++; if (bus.reg_d !== 8'hA5) begin errors++; $display("FAIL single_regd c%0d got %h exp a5", c, bus.reg_d); end
            checks++; if (bus.done !== ed) begin errors++; $display("FAIL single_done c%0d got %b exp %b", c, bus.done, ed); end
            checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL single_err c%0d got %b exp 0", c, bus.err); end
            checks++; if (bus.busy !== (c <= 2)) begin errors++; $display("FAIL single_busy c%0d got %b exp %b", c, bus.busy, (c <= 2)); end
            if (c == 3) bus.req = '0;
        end
    endtask

    task automatic test_simultaneous;
        logic [3:0] eg, ed;
        logic [7:0] edata;
        int         r;
        do_reset();
        bus.wdata = 32'h4433_2211;
        bus.req   = 4'b1111;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            eg = 4'b0000;
            ed = 4'b0000;
            if ((c - 1) % 3 == 0) begin
                r     = ((c - 1) / 3) % 4;
                eg    = 4'b0001 << r;
                edata = 8'((r + 1) * 17);
                checks++; if (bus.reg_d !== edata) begin errors++; $display("FAIL simul_regd c%0d got %h exp %h", c, bus.reg_d, edata); end
            end
            if (c % 3 == 0) begin
                ed = 4'b0001 << (((c / 3) - 1) % 4);
            end
            checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL simul_gnt c%0d got %b exp %b", c, bus.gnt, eg); end
            checks++; if (bus.done !== ed) begin errors++; $display("FAIL simul_done c%0d got %b exp %b", c, bus.done, ed); end
        end
        bus.req = '0;
    endtask

    task automatic test_fairness;
        logic [3:0] eg;
        do_reset();
        bus.wdata = 32'h4400_0011;
        bus.req   = 4'b1001;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            eg = 4'b0000;
            if ((c - 1) % 3 == 0) begin
                eg = ((((c - 1) / 3) % 2) == 0) ? 4'b0001 : 4'b1000;
            end
            checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL fair_gnt c%0d got %b exp %b", c, bus.gnt, eg); end
        end
        bus.req = '0;
    endtask

    task automatic test_retry_error;
        int  we_n, gnt_n;
        logic [3:0] ed;
        do_reset();
        stuck_en  = 1'b1;
        stuck_val = 8'h00;
        bus.wdata = 32'h0000_00FF;
        bus.req   = 4'b0001;
        we_n  = 0;
        gnt_n = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.reg_we === 1'b1) we_n++;
            if (bus.gnt !== 4'b0000) gnt_n++;
            ed = (c == 7) ? 4'b0001 : 4'b0000;
            checks++; if (bus.reg_we !== (c == 1 || c == 3 || c == 5)) begin errors++; $display("FAIL rerr_we c%0d got %b", c, bus.reg_we); end
            checks++; if (bus.done !== ed) begin errors++; $display("FAIL rerr_done c%0d got %b exp %b", c, bus.done, ed); end
            checks++; if (bus.err !== (c == 7)) begin errors++; $display("FAIL rerr_err c%0d got %b exp %b", c, bus.err, (c == 7)); end
            if (c == 7) bus.req = '0;
        end
        checks++; if (we_n != 3) begin errors++; $display("FAIL rerr_we_count got %0d exp 3", we_n); end
        checks++; if (gnt_n != 1) begin errors++; $display("FAIL rerr_gnt_count got %0d exp 1", gnt_n); end
        stuck_en = 1'b0;
    endtask

    task automatic test_retry_success;
        int  we_n;
        logic [3:0] ed;
        do_reset();
        corrupt_until = 1;
        bus.wdata = 32'h0000_005A;
        bus.req   = 4'b0001;
        we_n = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus.reg_we === 1'b1) we_n++;
            ed = (c == 5) ? 4'b0001 : 4'b0000;
            checks++; if (bus.done !== ed) begin errors++; $display("FAIL rok_done c%0d got %b exp %b", c, bus.done, ed); end
            checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rok_err c%0d got %b exp 0", c, bus.err); end
            if (c == 5) bus.req = '0;
        end
        checks++; if (we_n != 2) begin errors++; $display("FAIL rok_we_count got %0d exp 2", we_n); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.wdata = 32'h0000_00A5;
        bus.req   = 4'b0001;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b exp 1", bus.busy); end
        rst     = 1'b1;
        bus.req = 4'b1001;
        #1;
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt got %b exp 0000", bus.gnt); end
        checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL mid_we got %b exp 0", bus.reg_we); end
        checks++; if (bus.reg_d !== 8'h00) begin errors++; $display("FAIL mid_regd got %h exp 00", bus.reg_d); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", bus.busy); end
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL mid_done c%0d got %b exp 0000", c, bus.done); end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL mid_regrant got %b exp 0001", bus.gnt); end
        checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL mid_done_after got %b exp 0000", bus.done); end
        bus.req = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_retry_error();
        test_retry_success();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
